// File: rtl/sobel_window_controller_pkg.sv
// Shared types for the Sobel front end and gradient blocks.
// Pixel width, window size and the controller state encoding.
package sobel_pkg;

  localparam int PIXEL_W     = 8;
  localparam int WINDOW_SIZE = 9;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

endpackage

// File: rtl/sobel_window_controller_if.sv
// Pixel stream in, 3x3 window out, between the
// raster source and the gradient stage.
interface sobel_window_controller_if;
  import sobel_pkg::*;

  pixel_t pixel_in;
  logic   pixel_valid;
  logic   stall;
  logic   pixel_ready;
  pixel_t windowBuffer [0:WINDOW_SIZE-1];
  logic   start_calculations;
  logic   frame_done;

  modport master (
    output pixel_in,
    output pixel_valid,
    output stall,
    input  pixel_ready,
    input  windowBuffer,
    input  start_calculations,
    input  frame_done
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid,
    input  stall,
    output pixel_ready,
    output windowBuffer,
    output start_calculations,
    output frame_done
  );

endinterface

// File: rtl/sobel_window_controller_line_buffer.sv
// Fixed-depth pixel delay line; advances only when en_i is set.
// Output is the pixel written DEPTH enables ago.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   en_i,
  input  pixel_t d_i,
  output pixel_t q_o
);

  pixel_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_window_controller.sv
// Builds a sliding 3x3 window from a raster pixel stream and
// flags each window that lies fully inside the frame.
module sobel_window_controller
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input logic clk,
  input logic n_rst,
  sobel_window_controller_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  state_e        state_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          start_q;
  logic          done_q;
  pixel_t        win_q [0:WINDOW_SIZE-1];
  pixel_t        l0, l1;
  logic          accept;
  logic          last_col, last_row;

  assign bus.pixel_ready = !bus.stall && (state_q != DONE);
  assign accept   = bus.pixel_valid && bus.pixel_ready;
  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    col_d = col_q + CW'(1);
    row_d = row_q;
    if (last_col) begin
      col_d = '0;
      row_d = last_row ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= accept && (row_q >= RW'(2))
                        && (col_q >= CW'(2));
      done_q  <= 1'b0;
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      unique case (state_q)
        IDLE: if (accept) state_q <= STREAM;
        STREAM: begin
          if (accept && last_col && last_row) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line0 (
    .clk  (clk),
    .n_rst(n_rst),
    .en_i (accept),
    .d_i  (bus.pixel_in),
    .q_o  (l0)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
    .clk  (clk),
    .n_rst(n_rst),
    .en_i (accept),
    .d_i  (l0),
    .q_o  (l1)
  );

  // Right column: two rows back, one row back, current pixel.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < WINDOW_SIZE; i++) win_q[i] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[3*r]   <= win_q[3*r+1];
        win_q[3*r+1] <= win_q[3*r+2];
      end
      win_q[2] <= l1;
      win_q[5] <= l0;
      win_q[8] <= bus.pixel_in;
    end
  end

  assign bus.windowBuffer       = win_q;
  assign bus.start_calculations = start_q;
  assign bus.frame_done         = done_q;

endmodule
